// File: rtl/usrp2puf_pkg.sv
// rtl/usrp2puf_pkg.sv - shared phase, weight and rounding definitions for the 5->4 resampler
package usrp2puf_pkg;

    localparam logic [2:0] P0 = 3'd0;
    localparam logic [2:0] P1 = 3'd1;
    localparam logic [2:0] P2 = 3'd2;
    localparam logic [2:0] P3 = 3'd3;
    localparam logic [2:0] P4 = 3'd4;

    // Weight pair selector; the first-named weight applies to the previous sample
    typedef enum logic [1:0] {
        WSEL_3Q,
        WSEL_HALF,
        WSEL_1Q
    } wsel_t;

    function automatic int w_3q(input int dw);
        return 3 * (1 << (dw - 3));
    endfunction

    function automatic int w_half(input int dw);
        return 1 << (dw - 2);
    endfunction

    function automatic int w_1q(input int dw);
        return 1 << (dw - 3);
    endfunction

    function automatic int rnd_const(input int dw);
        return 1 << (dw - 2);
    endfunction

endpackage

// File: rtl/usrp2puf_lerp_comp.sv
// rtl/usrp2puf_lerp_comp.sv - two-stage weighted blend of one signed component
module lerp_comp
    import usrp2puf_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ce,
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    input  wsel_t                wsel,
    input  logic                 bypass,
    output logic signed [DW-1:0] y
);

    localparam int PW = 2 * DW;
    localparam int SW = 2 * DW + 1;

    localparam logic signed [PW-1:0] K_3Q   = PW'(w_3q(DW));
    localparam logic signed [PW-1:0] K_HALF = PW'(w_half(DW));
    localparam logic signed [PW-1:0] K_1Q   = PW'(w_1q(DW));
    localparam logic signed [SW-1:0] K_RND  = SW'(rnd_const(DW));
    localparam logic signed [SW-1:0] SAT_MAX = SW'((1 << (DW - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    logic signed [PW-1:0] wa;
    logic signed [PW-1:0] wb;
    logic signed [PW-1:0] s1_pa;
    logic signed [PW-1:0] s1_pb;
    logic signed [DW-1:0] s1_x;
    logic                 s1_bypass;
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] shifted;
    logic signed [DW-1:0] sat_val;

    assign a_ext = {{DW{a[DW-1]}}, a};
    assign b_ext = {{DW{b[DW-1]}}, b};

    always_comb begin
        wa = K_HALF;
        wb = K_HALF;
        case (wsel)
            WSEL_3Q: begin
                wa = K_3Q;
                wb = K_1Q;
            end
            WSEL_1Q: begin
                wa = K_1Q;
                wb = K_3Q;
            end
            default: begin
                wa = K_HALF;
                wb = K_HALF;
            end
        endcase
    end

    // Round half up before the arithmetic shift back to sample scale
    assign sum     = {s1_pa[PW-1], s1_pa} + {s1_pb[PW-1], s1_pb} + K_RND;
    assign shifted = sum >>> (DW - 1);

    always_comb begin
        sat_val = shifted[DW-1:0];
        if (shifted > SAT_MAX) begin
            sat_val = SAT_MAX[DW-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_val = SAT_MIN[DW-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_pa     <= '0;
            s1_pb     <= '0;
            s1_x      <= '0;
            s1_bypass <= 1'b0;
            y         <= '0;
        end else if (ce) begin
            s1_pa     <= a_ext * wa;
            s1_pb     <= b_ext * wb;
            s1_x      <= b;
            s1_bypass <= bypass;
            y         <= s1_bypass ? s1_x : sat_val;
        end
    end

endmodule

// File: rtl/usrp2puf.sv
// rtl/usrp2puf.sv - 5-in/4-out linear-interpolating resampler, USRP to PUF sample domain
module usrp2puf
    import usrp2puf_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [2*DATA_WIDTH-1:0] in_tdata,
    input  logic                    in_tvalid,
    input  logic                    in_tlast,
    output logic                    in_tready,
    output logic [2*DATA_WIDTH-1:0] out_tdata,
    output logic                    out_tvalid,
    output logic                    out_tlast,
    input  logic                    out_tready
);

    localparam int DW = DATA_WIDTH;

    logic [2:0]      phase;
    logic [2:0]      phase_next;
    logic [2*DW-1:0] prev;
    logic            ce;
    logic            accept;
    logic            emit;
    logic            bypass;
    wsel_t           wsel;
    logic            s1_valid;
    logic            s1_last;

    assign ce        = out_tready | ~out_tvalid;
    assign in_tready = ce;
    assign accept    = in_tvalid & ce;

    always_comb begin
        phase_next = phase;
        wsel       = WSEL_HALF;
        bypass     = 1'b0;
        case (phase)
            P0: bypass = 1'b1;
            // A packet ending on the store-only phase still emits its last sample
            P1: bypass = in_tlast;
            P2: wsel = WSEL_3Q;
            P3: wsel = WSEL_HALF;
            P4: wsel = WSEL_1Q;
            default: bypass = 1'b0;
        endcase
        emit = accept & ((phase != P1) | in_tlast);
        if (accept) begin
            phase_next = (in_tlast || phase == P4) ? P0 : phase + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase      <= P0;
            prev       <= '0;
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            out_tvalid <= 1'b0;
            out_tlast  <= 1'b0;
        end else begin
            phase <= phase_next;
            if (accept) begin
                prev <= in_tdata;
            end
            if (ce) begin
                s1_valid   <= emit;
                s1_last    <= emit & in_tlast;
                out_tvalid <= s1_valid;
                out_tlast  <= s1_valid & s1_last;
            end
        end
    end

    lerp_comp #(.DW(DW)) u_lerp_i (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (ce),
        .a       (prev[2*DW-1:DW]),
        .b       (in_tdata[2*DW-1:DW]),
        .wsel    (wsel),
        .bypass  (bypass),
        .y       (out_tdata[2*DW-1:DW])
    );

    lerp_comp #(.DW(DW)) u_lerp_q (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (ce),
        .a       (prev[DW-1:0]),
        .b       (in_tdata[DW-1:0]),
        .wsel    (wsel),
        .bypass  (bypass),
        .y       (out_tdata[DW-1:0])
    );

endmodule

// File: tb/tb_usrp2puf.sv
// tb/tb_usrp2puf.sv - directed self-checking bench for usrp2puf
module tb_usrp2puf;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] in_tdata = '0;
    logic        in_tvalid = 1'b0;
    logic        in_tlast = 1'b0;
    logic        in_tready;
    logic [31:0] out_tdata;
    logic        out_tvalid;
    logic        out_tlast;
    logic        out_tready = 1'b1;

    usrp2puf #(.DATA_WIDTH(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_tdata   (in_tdata),
        .in_tvalid  (in_tvalid),
        .in_tlast   (in_tlast),
        .in_tready  (in_tready),
        .out_tdata  (out_tdata),
        .out_tvalid (out_tvalid),
        .out_tlast  (out_tlast),
        .out_tready (out_tready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int i;
        int q;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    int   log_i[$];
    int   log_q[$];
    int   log_l[$];

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   first_acc = -1;
    int   first_out = -1;
    bit   rnd_mode = 1'b0;
    bit   stall_prev = 1'b0;
    logic [31:0] held_data;
    logic        held_last;

    int   m_phase = 0;
    int   m_prev_i = 0;
    int   m_prev_q = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Blend in quarters: phase n weighs prev by (5-n)/4 and x by (n-1)/4, rounded half up
    function automatic int blend(input int p, input int x, input int ph);
        int n;
        int r;
        n = (5 - ph) * p + (ph - 1) * x + 2;
        r = (n >= 0) ? n / 4 : -((-n + 3) / 4);
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    task automatic model_accept(input int xi, input int xq, input bit last);
        exp_t e;
        if (m_phase == 0 || m_phase == 1) begin
            if (m_phase == 0 || last) begin
                e.i = xi; e.q = xq; e.last = last;
                exp_q.push_back(e);
            end
        end else begin
            e.i = blend(m_prev_i, xi, m_phase);
            e.q = blend(m_prev_q, xq, m_phase);
            e.last = last;
            exp_q.push_back(e);
        end
        m_prev_i = xi;
        m_prev_q = xq;
        m_phase  = last ? 0 : (m_phase + 1) % 5;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_phase  = 0;
        m_prev_i = 0;
        m_prev_q = 0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        out_tready = rnd_mode ? 1'($urandom & 1) : 1'b1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid_held", int'(out_tvalid), 1);
                chk("stall_data_held", int'(out_tdata == held_data), 1);
                chk("stall_last_held", int'(out_tlast), int'(held_last));
            end
            if (out_tvalid && !out_tready) begin
                chk("in_tready_during_stall", int'(in_tready), 0);
            end
            stall_prev = out_tvalid && !out_tready;
            held_data  = out_tdata;
            held_last  = out_tlast;

            if (in_tvalid && in_tready) begin
                model_accept(int'($signed(in_tdata[31:16])), int'($signed(in_tdata[15:0])), in_tlast);
                if (first_acc < 0) first_acc = cyc;
            end
            if (out_tvalid && first_acc >= 0 && first_out < 0) first_out = cyc;
            if (out_tvalid && out_tready) begin
                log_i.push_back(int'($signed(out_tdata[31:16])));
                log_q.push_back(int'($signed(out_tdata[15:0])));
                log_l.push_back(int'(out_tlast));
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_i", int'($signed(out_tdata[31:16])), e.i);
                    chk("out_q", int'($signed(out_tdata[15:0])), e.q);
                    chk("out_last", int'(out_tlast), int'(e.last));
                end
            end
        end
    end

    task automatic send(input int i, input int q, input bit last);
        int n;
        bit ok;
        logic [31:0] iv;
        logic [31:0] qv;
        iv = i;
        qv = q;
        in_tdata  = {iv[15:0], qv[15:0]};
        in_tvalid = 1'b1;
        in_tlast  = last;
        n  = 0;
        ok = 1'b0;
        do begin
            @(negedge clk);
            ok = in_tready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic drain(input string tag);
        int n;
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_drained"}, exp_q.size(), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_i.delete();
        log_q.delete();
        log_l.delete();
    endtask

    function automatic int li(input int k);
        return (k < log_i.size()) ? log_i[k] : -99999;
    endfunction

    function automatic int lq(input int k);
        return (k < log_q.size()) ? log_q[k] : -99999;
    endfunction

    function automatic int ll(input int k);
        return (k < log_l.size()) ? log_l[k] : -1;
    endfunction

    task automatic check_ramp_log(input string tag);
        chk({tag, "_count"}, log_i.size(), 8);
        for (int k = 0; k < 8; k++) begin
            chk({tag, "_lit_i"}, li(k), 125 * k);
            chk({tag, "_lit_q"}, lq(k), 0);
        end
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_tvalid", int'(out_tvalid), 0);
        chk("rst_out_tlast", int'(out_tlast), 0);
        chk("rst_out_tdata", int'(out_tdata), 0);
        chk("rst_in_tready", int'(in_tready), 1);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // constant input
        clear_log();
        first_acc = -1;
        first_out = -1;
        for (int k = 0; k < 10; k++) send(1000, -1000, 1'b0);
        drain("const");
        chk("const_count", log_i.size(), 8);
        for (int k = 0; k < 8; k++) begin
            chk("const_lit_i", li(k), 1000);
            chk("const_lit_q", lq(k), -1000);
        end
        chk("first_latency", first_out - first_acc, 2);

        // ramp, new packet
        send(0, 0, 1'b1);
        drain("align");
        clear_log();
        for (int k = 0; k < 10; k++) send(100 * k, 0, 1'b0);
        drain("ramp");
        check_ramp_log("ramp");

        // rounding at phase 2
        send(0, 0, 1'b1);
        drain("align2");
        clear_log();
        send(0, 0, 1'b0); send(1, 0, 1'b0); send(2, 0, 1'b1);
        send(0, 0, 1'b0); send(1, 0, 1'b0); send(3, 0, 1'b1);
        drain("round");
        chk("round_1p25", li(1), 1);
        chk("round_1p25_last", ll(1), 1);
        chk("round_1p5", li(3), 2);

        // full scale, I negative and Q positive
        clear_log();
        send(0, 0, 1'b0);
        for (int k = 0; k < 4; k++) send(-32768, 32767, k == 3);
        drain("fullscale");
        chk("fs_p3_i", li(2), -32768);
        chk("fs_p3_q", lq(2), 32767);
        chk("fs_p4_i", li(3), -32768);
        chk("fs_p4_q", lq(3), 32767);

        // ramp under random backpressure
        clear_log();
        rnd_mode = 1'b1;
        for (int k = 0; k < 10; k++) send(100 * k, 0, 1'b0);
        drain("rnd_ramp");
        rnd_mode = 1'b0;
        check_ramp_log("rnd_ramp");

        // packet ending on the store-only phase
        send(0, 0, 1'b1);
        drain("align3");
        clear_log();
        for (int k = 0; k < 7; k++) send(100 * k, 0, k == 6);
        send(700, 0, 1'b0);
        send(800, 0, 1'b1);
        drain("tlast");
        chk("tlast_count", log_i.size(), 8);
        chk("tlast_o4", li(4), 500);
        chk("tlast_o5", li(5), 600);
        chk("tlast_o5_last", ll(5), 1);
        for (int k = 0; k < 5; k++) chk("tlast_early_clear", ll(k), 0);
        chk("next_pkt_bypass", li(6), 700);
        chk("next_pkt_tail", li(7), 800);

        // asynchronous reset mid-stream
        for (int k = 0; k < 4; k++) send(100 * k, 0, 1'b0);
        chk("pre_rst_valid", int'(out_tvalid), 1);
        #2;
        reset_n   = 1'b0;
        in_tvalid = 1'b0;
        model_reset();
        #1;
        chk("async_rst_valid", int'(out_tvalid), 0);
        chk("async_rst_data", int'(out_tdata), 0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        clear_log();
        for (int k = 0; k < 10; k++) send(100 * k, 0, 1'b0);
        drain("post_rst");
        check_ramp_log("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
